// File: rtl/biquad_mac_sequencer.sv
// Time-multiplexed Direct-Form-II biquad built around one shared multiply-accumulate unit.
// The five coefficient products are scheduled over five clocks by a small FSM.
// Optional build macro: BIQUAD_MAC_SEQUENCER_SAT_EN selects saturating arithmetic
// (wrapping two's complement otherwise).
module biquad_mac_sequencer #(
  parameter int unsigned Width     = 25,
  parameter int unsigned Presicion = 16
) (
  input  logic                    clock44k,
  input  logic                    reset,
  input  logic                    start,
  input  logic signed [Width-1:0] uk,
  input  logic                    coef_we,
  input  logic [2:0]              coef_addr,
  input  logic signed [Width-1:0] coef_data,
  output logic                    busy,
  output logic                    done,
  output logic signed [Width-1:0] yk
);

  localparam int unsigned PW = 2 * Width;
  localparam int unsigned HW = PW - Presicion;
  localparam logic signed [Width-1:0] MaxVal = {1'b0, {(Width-1){1'b1}}};
  localparam logic signed [Width-1:0] MinVal = {1'b1, {(Width-1){1'b0}}};
  localparam logic signed [Width-1:0] One    = Width'(1) << Presicion;

  typedef enum logic [2:0] {StIdle, StFb1, StFb2, StFf0, StFf1, StFf2} state_e;

  state_e                  state_q, state_d;
  logic signed [Width-1:0] uk_q, uk_d, acc_q, acc_d, fk_q, fk_d;
  logic signed [Width-1:0] w1_q, w1_d, w2_q, w2_d, yk_q, yk_d;
  logic                    done_q, done_d;
  logic signed [Width-1:0] b0_q, b1_q, b2_q, a1_q, a2_q;

  logic signed [Width-1:0] mul_a, mul_b, acc_base, prod_r, mac_res;
  logic                    do_sub;
  logic signed [PW-1:0]    mul_a_x, mul_b_x, prod_full;
  logic [HW-1:0]           prod_hi;
  logic signed [Width:0]   sum_w;
  logic                    coef_wr_ok;
  logic                    unused_bits;

  assign busy = (state_q != StIdle);
  assign done = done_q;
  assign yk   = yk_q;

  // Writes are only honoured when the FSM is idle and not accepting a sample this cycle.
  assign coef_wr_ok = coef_we && (state_q == StIdle) && !start;

  // Operand and accumulator-source selection for the shared MAC.
  always_comb begin
    mul_a    = '0;
    mul_b    = '0;
    acc_base = '0;
    do_sub   = 1'b0;
    unique case (state_q)
      StFb1: begin mul_a = a1_q; mul_b = w1_q; acc_base = uk_q;  do_sub = 1'b1; end
      StFb2: begin mul_a = a2_q; mul_b = w2_q; acc_base = acc_q; do_sub = 1'b1; end
      StFf0: begin mul_a = b0_q; mul_b = fk_q; end
      StFf1: begin mul_a = b1_q; mul_b = w1_q; acc_base = acc_q; end
      StFf2: begin mul_a = b2_q; mul_b = w2_q; acc_base = acc_q; end
      default: ;
    endcase
  end

  // The single multiplier: full-width signed product, then arithmetic shift by Presicion.
  assign mul_a_x   = {{Width{mul_a[Width-1]}}, mul_a};
  assign mul_b_x   = {{Width{mul_b[Width-1]}}, mul_b};
  assign prod_full = mul_a_x * mul_b_x;
  assign prod_hi   = prod_full[PW-1:Presicion];

  assign sum_w = do_sub ? ({acc_base[Width-1], acc_base} - {prod_r[Width-1], prod_r})
                        : ({acc_base[Width-1], acc_base} + {prod_r[Width-1], prod_r});

`ifdef BIQUAD_MAC_SEQUENCER_SAT_EN
  // Clamp whenever the discarded upper bits are not a pure sign extension.
  always_comb begin
    prod_r = prod_hi[Width-1:0];
    if (!((&prod_hi[HW-1:Width-1]) || !(|prod_hi[HW-1:Width-1]))) begin
      prod_r = prod_hi[HW-1] ? MinVal : MaxVal;
    end
    mac_res = sum_w[Width-1:0];
    if (sum_w[Width] != sum_w[Width-1]) begin
      mac_res = sum_w[Width] ? MinVal : MaxVal;
    end
  end
`else
  // Wrapping build: keep the low Width bits of every intermediate.
  always_comb begin
    prod_r  = prod_hi[Width-1:0];
    mac_res = sum_w[Width-1:0];
  end
`endif

  assign unused_bits = ^{prod_full[Presicion-1:0], prod_hi[HW-1:Width-1], sum_w[Width]};

  // Next-state and datapath register updates for the sequencer.
  always_comb begin
    state_d = state_q;
    uk_d    = uk_q;
    acc_d   = acc_q;
    fk_d    = fk_q;
    w1_d    = w1_q;
    w2_d    = w2_q;
    yk_d    = yk_q;
    done_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          uk_d    = uk;
          state_d = StFb1;
        end
      end
      StFb1: begin acc_d = mac_res; state_d = StFb2; end
      StFb2: begin acc_d = mac_res; fk_d = mac_res; state_d = StFf0; end
      StFf0: begin acc_d = mac_res; state_d = StFf1; end
      StFf1: begin acc_d = mac_res; state_d = StFf2; end
      StFf2: begin
        acc_d   = mac_res;
        yk_d    = mac_res;
        w2_d    = w1_q;
        w1_d    = fk_q;
        done_d  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // FSM and datapath state; reset aborts any sample in flight.
  always_ff @(posedge clock44k) begin
    if (reset) begin
      state_q <= StIdle;
      uk_q    <= '0;
      acc_q   <= '0;
      fk_q    <= '0;
      w1_q    <= '0;
      w2_q    <= '0;
      yk_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      uk_q    <= uk_d;
      acc_q   <= acc_d;
      fk_q    <= fk_d;
      w1_q    <= w1_d;
      w2_q    <= w2_d;
      yk_q    <= yk_d;
      done_q  <= done_d;
    end
  end

  // Coefficient bank, reset to passthrough (b0 = 1.0, all others 0).
  always_ff @(posedge clock44k) begin
    if (reset) begin
      b0_q <= One;
      b1_q <= '0;
      b2_q <= '0;
      a1_q <= '0;
      a2_q <= '0;
    end else if (coef_wr_ok) begin
      case (coef_addr)
        3'd0:    b0_q <= coef_data;
        3'd1:    b1_q <= coef_data;
        3'd2:    b2_q <= coef_data;
        3'd3:    a1_q <= coef_data;
        3'd4:    a2_q <= coef_data;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_biquad_mac_sequencer.sv
// Scoreboard bench for biquad_mac_sequencer: stimulus pushes expected yk values,
// a monitor pops and compares on every done pulse.
module tb_biquad_mac_sequencer;

  logic               clk;
  logic               reset;
  logic               start;
  logic signed [24:0] uk;
  logic               coef_we;
  logic [2:0]         coef_addr;
  logic signed [24:0] coef_data;
  logic               busy;
  logic               done;
  logic signed [24:0] yk;

  int checks = 0;
  int errors = 0;
  logic signed [24:0] exp_q[$];

  biquad_mac_sequencer #(.Width(25), .Presicion(16)) dut (
    .clock44k (clk),
    .reset    (reset),
    .start    (start),
    .uk       (uk),
    .coef_we  (coef_we),
    .coef_addr(coef_addr),
    .coef_data(coef_data),
    .busy     (busy),
    .done     (done),
    .yk       (yk)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Absolute guard so the run always ends.
  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish, required finish");
    $fatal(1);
  end

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  // Monitor: every done pulse must match the oldest expected value.
  initial begin
    logic signed [24:0] e;
    forever begin
      @(negedge clk);
      if (done) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_done: got done with yk=%0d, required no done", yk);
        end else begin
          e = exp_q.pop_front();
          if (yk !== e) begin
            errors++;
            $display("FAIL yk: got %0d, required %0d", yk, e);
          end
        end
      end
    end
  end

  task automatic wait_drain();
    for (int i = 0; i < 30 && exp_q.size() != 0; i++) @(negedge clk);
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: got %0d pending outputs, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic send(input int x, input int e);
    exp_q.push_back(25'(e));
    @(posedge clk); #1;
    start = 1'b1;
    uk    = 25'(x);
    @(posedge clk); #1;
    start = 1'b0;
    wait_drain();
  endtask

  task automatic wr(input int a, input int d);
    @(posedge clk); #1;
    coef_we   = 1'b1;
    coef_addr = 3'(a);
    coef_data = 25'(d);
    @(posedge clk); #1;
    coef_we   = 1'b0;
  endtask

  task automatic pulse_reset();
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; uk = '0;
    coef_we = 1'b0; coef_addr = '0; coef_data = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("reset_busy", int'(busy), 0);
    check("reset_done", int'(done), 0);
    check("reset_yk", int'(yk), 0);

    // Passthrough with exact handshake timing.
    exp_q.push_back(25'd4096);
    @(posedge clk); #1;
    start = 1'b1;
    uk    = 25'd4096;
    @(posedge clk); #1;
    start = 1'b0;
    for (int n = 1; n <= 6; n++) begin
      @(negedge clk);
      check($sformatf("pt_busy_c%0d", n), int'(busy), (n <= 5) ? 1 : 0);
      check($sformatf("pt_done_c%0d", n), int'(done), (n == 6) ? 1 : 0);
    end
    wait_drain();

    // Gain 0.5 via write path; ignored address in between.
    wr(0, 32768);
    wr(5, 999);
    send(65536, 32768);
    send(-65536, -32768);

    // First-order recursion: y[n] = x[n] + 0.5*y[n-1].
    pulse_reset();
    wr(3, -32768);
    send(65536, 65536);
    send(0, 32768);
    send(0, 16384);

    // Overflow at gain 2.0 on the largest positive sample.
    pulse_reset();
    wr(0, 131072);
`ifdef BIQUAD_MAC_SEQUENCER_SAT_EN
    send(16777215, 16777215);
`else
    send(16777215, -2);
`endif

    // Collision: start during cycle 3 of a sample is ignored.
    pulse_reset();
    exp_q.push_back(25'd300);
    @(posedge clk); #1; start = 1'b1; uk = 25'd300;
    @(posedge clk); #1; start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1; start = 1'b1; uk = 25'd999;
    @(posedge clk); #1; start = 1'b0; uk = '0;
    wait_drain();
    repeat (12) @(posedge clk);

    // Collision: coefficient write while busy is dropped.
    exp_q.push_back(25'd400);
    @(posedge clk); #1; start = 1'b1; uk = 25'd400;
    @(posedge clk); #1; start = 1'b0;
    @(posedge clk); #1; coef_we = 1'b1; coef_addr = 3'd0; coef_data = 25'd32768;
    @(posedge clk); #1; coef_we = 1'b0;
    wait_drain();
    send(500, 500);

    // Collision: write together with an accepted start is dropped.
    exp_q.push_back(25'd600);
    @(posedge clk); #1;
    start = 1'b1; uk = 25'd600;
    coef_we = 1'b1; coef_addr = 3'd0; coef_data = 25'd32768;
    @(posedge clk); #1; start = 1'b0; coef_we = 1'b0;
    wait_drain();
    send(700, 700);

    // Feed-forward using state: 0.5*1000 + 1.0*w1(700).
    wr(0, 32768);
    wr(1, 65536);
    send(1000, 1200);

    // Reset during FF0 aborts the sample and restores passthrough.
    @(posedge clk); #1; start = 1'b1; uk = 25'd2000;
    @(posedge clk); #1; start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1; reset = 1'b1;
    @(posedge clk); #1; reset = 1'b0;
    @(negedge clk);
    check("abort_busy", int'(busy), 0);
    check("abort_yk", int'(yk), 0);
    check("abort_done", int'(done), 0);
    repeat (10) @(posedge clk);
    send(100, 100);
    // w1 is now 100; b1 must be back to 0.
    send(0, 0);

    repeat (4) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
